// File: rtl/bus_arb.sv
// bus_arb: arbitrates the external memory bus between the instruction-fetch
// (I) side and the data (D) side of the hart. Each transfer is a fixed
// burst of BEATS beats. D-side locked reads (AMO) keep the bus reserved
// until the paired write or until the lock is dropped.
//
// Optional build macro BUS_ARB_RR_EN: when defined, simultaneous I/D
// requests from IDLE alternate using a last_gnt register. When it is
// undefined, D has fixed priority over I.
module bus_arb #(
    parameter int AW    = 64,
    parameter int DW    = 64,
    parameter int BEATS = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_data,
    output logic          i_vld,
    output logic          i_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_lock,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_wrd,
    output logic [DW-1:0] d_rdata,
    output logic          d_vld,
    output logic          d_done,
    output logic          b_req,
    output logic          b_we,
    output logic [AW-1:0] b_addr,
    output logic [DW-1:0] b_wdata,
    input  logic [DW-1:0] b_rdata,
    input  logic          b_ack,
    output logic          b_rd_i,
    output logic          b_rd_d
);

    localparam int            CW       = $clog2(BEATS);
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);
    localparam logic [AW-1:0] STRIDE   = AW'(DW / 8);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_XFER = 2'd1,
        D_XFER = 2'd2,
        D_LOCK = 2'd3
    } state_t;

    state_t        state_r, state_nxt;
    logic [CW-1:0] cnt_r, cnt_nxt;
    logic [AW-1:0] base_r, base_nxt;
    logic          we_r, we_nxt;
    logic          lock_r, lock_nxt;

    logic          pick_d_s;
    logic          xfer_s;
    logic          beat_s;
    logic          last_s;

`ifdef BUS_ARB_RR_EN
    logic          last_gnt_r;

    // Alternating choice: on a tie, grant the side that was not granted last
    always_comb begin
        if (d_req && i_req) begin
            pick_d_s = ~last_gnt_r;
        end else begin
            pick_d_s = d_req;
        end
    end

    // Remember which side won the most recent grant out of IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_r <= 1'b0;
        end else if (state_r == IDLE && (d_req || i_req)) begin
            last_gnt_r <= pick_d_s;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end
`else
    // Fixed priority: D always wins over I
    always_comb begin
        pick_d_s = d_req;
    end
`endif

    assign xfer_s = (state_r == I_XFER) || (state_r == D_XFER);
    assign beat_s = xfer_s && b_ack;
    assign last_s = (cnt_r == LAST_CNT);

    // Next-state, beat counter and grant-latch logic
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        base_nxt  = base_r;
        we_nxt    = we_r;
        lock_nxt  = lock_r;
        case (state_r)
            IDLE: begin
                cnt_nxt = '0;
                if (pick_d_s) begin
                    state_nxt = D_XFER;
                    base_nxt  = d_addr;
                    we_nxt    = d_we;
                    lock_nxt  = d_lock;
                end else if (i_req) begin
                    state_nxt = I_XFER;
                    base_nxt  = i_addr;
                    we_nxt    = 1'b0;
                    lock_nxt  = 1'b0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            I_XFER, D_XFER: begin
                if (b_ack) begin
                    if (last_s) begin
                        cnt_nxt = '0;
                        if (state_r == D_XFER && lock_r && !we_r) begin
                            state_nxt = D_LOCK;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt_r + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt_r;
                end
            end
            D_LOCK: begin
                cnt_nxt = '0;
                if (d_req && d_we) begin
                    // the paired write wins even if the lock drops together
                    state_nxt = D_XFER;
                    base_nxt  = d_addr;
                    we_nxt    = 1'b1;
                    lock_nxt  = 1'b0;
                end else if (!d_lock) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = D_LOCK;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            base_r  <= '0;
            we_r    <= 1'b0;
            lock_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            base_r  <= base_nxt;
            we_r    <= we_nxt;
            lock_r  <= lock_nxt;
        end
    end

    // Bus side: request, direction and beat address come straight from registers
    always_comb begin
        if (xfer_s) begin
            b_req  = 1'b1;
            b_we   = (state_r == D_XFER) && we_r;
            b_addr = base_r + (AW'(cnt_r) * STRIDE);
        end else begin
            b_req  = 1'b0;
            b_we   = 1'b0;
            b_addr = '0;
        end
    end

    // Requester strobes qualify the bus acknowledge with the active side
    always_comb begin
        i_vld  = beat_s && (state_r == I_XFER);
        i_done = beat_s && (state_r == I_XFER) && last_s;
        d_vld  = beat_s && (state_r == D_XFER) && !we_r;
        d_wrd  = beat_s && (state_r == D_XFER) && we_r;
        d_done = beat_s && (state_r == D_XFER) && last_s;
    end

    assign i_data  = b_rdata;
    assign d_rdata = b_rdata;
    assign b_wdata = d_wdata;

    // stall flags drop in the done cycle so the pipeline can advance at once
    assign b_rd_i = i_req && !i_done;
    assign b_rd_d = d_req && !d_done;

endmodule

// File: tb/tb_bus_arb.sv
// Randomized scoreboard bench for bus_arb (AW=64, DW=64, BEATS=8).
// Stimulus pushes the expected bus beats of each burst, in the order the
// arbitration rules dictate, into a queue; a negedge monitor pops one entry
// per acknowledged beat and checks address, direction and requester strobes.
module tb_bus_arb;

    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int BEATS = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we, d_lock, b_ack;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, b_rdata;
    logic [DW-1:0] i_data, d_rdata, b_wdata;
    logic          i_vld, i_done, d_wrd, d_vld, d_done;
    logic          b_req, b_we, b_rd_i, b_rd_d;
    logic [AW-1:0] b_addr;

    bus_arb #(.AW(AW), .DW(DW), .BEATS(BEATS)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_vld(i_vld), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wrd(d_wrd), .d_rdata(d_rdata), .d_vld(d_vld), .d_done(d_done),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ack(b_ack), .b_rd_i(b_rd_i), .b_rd_d(b_rd_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            side_d;
        bit            we;
        logic [AW-1:0] addr;
        bit            last;
    } beat_t;

    beat_t sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    done_i_cnt = 0;
    int    done_d_cnt = 0;
    int    beats_seen = 0;
    int    wrd_cnt = 0;
    bit    mon_en = 1'b0;
    bit    prev_done = 1'b0;
    int    ack_mode = 3;   // 0 random, 1 always, 2 toggle, 3 never
    bit    model_last = 1'b0;  // 1 = D granted most recently from IDLE

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_burst(input bit side_d, input bit we, input logic [AW-1:0] base);
        beat_t e;
        for (int k = 0; k < BEATS; k++) begin
            e.side_d = side_d;
            e.we     = we;
            e.addr   = base + 64'(k * (DW / 8));
            e.last   = (k == BEATS - 1);
            sb.push_back(e);
        end
    endtask

    // advance one cycle and drive fresh slave/data values away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
        b_rdata = {$urandom, $urandom};
        d_wdata = {$urandom, $urandom};
        case (ack_mode)
            0: b_ack = 1'($urandom_range(0, 1));
            1: b_ack = 1'b1;
            2: b_ack = ~b_ack;
            default: b_ack = 1'b0;
        endcase
    endtask

    task automatic wait_done(input bit side_d);
        int start;
        int n;
        start = side_d ? done_d_cnt : done_i_cnt;
        n = 0;
        while ((side_d ? done_d_cnt : done_i_cnt) == start && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: side_d=%0d no done within %0d cycles", side_d, n);
        end
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        logic [AW-1:0] a;
        a = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) a = 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(0, 15));
        return a;
    endfunction

    // single-side burst with grant-latency check
    task automatic one_burst(input bit side_d, input bit we, input logic [AW-1:0] a);
        push_burst(side_d, we, a);
        if (side_d) begin
            d_addr = a; d_we = we; d_lock = 1'b0; d_req = 1'b1;
        end else begin
            i_addr = a; i_req = 1'b1;
        end
        chk("grant_not_early", b_req, 1'b0);
        tick();
        chk("grant_latency", b_req, 1'b1);
        wait_done(side_d);
        if (side_d) begin
            d_req = 1'b0; d_we = 1'b0;
            model_last = 1'b1;
        end else begin
            i_req = 1'b0;
            model_last = 1'b0;
        end
    endtask

    // I and D raised in the same cycle; order follows the arbitration rule
    task automatic both_burst(input logic [AW-1:0] ad, input bit wd, input logic [AW-1:0] ai);
        bit d_first;
        int di;
        int dd;
        int n;
`ifdef BUS_ARB_RR_EN
        d_first = (model_last == 1'b0);
`else
        d_first = 1'b1;
`endif
        if (d_first) begin
            push_burst(1'b1, wd, ad); push_burst(1'b0, 1'b0, ai);
        end else begin
            push_burst(1'b0, 1'b0, ai); push_burst(1'b1, wd, ad);
        end
        d_addr = ad; d_we = wd; d_lock = 1'b0; i_addr = ai;
        d_req = 1'b1; i_req = 1'b1;
        di = done_i_cnt; dd = done_d_cnt; n = 0;
        while ((d_req || i_req) && n < 600) begin
            tick();
            n++;
            if (done_d_cnt != dd) begin d_req = 1'b0; d_we = 1'b0; dd = done_d_cnt; end
            if (done_i_cnt != di) begin i_req = 1'b0; di = done_i_cnt; end
        end
        if (n >= 600) begin
            n_cmp++; n_err++;
            $display("FAIL both_timeout: requests still pending after %0d cycles", n);
            d_req = 1'b0; i_req = 1'b0;
        end
        model_last = d_first ? 1'b0 : 1'b1;
    endtask

    // locked read, optional I request during the lock, then write or unlock
    task automatic lock_seq(input logic [AW-1:0] a, input bit do_write, input bit i_during,
                            input logic [AW-1:0] ai);
        push_burst(1'b1, 1'b0, a);
        d_addr = a; d_we = 1'b0; d_lock = 1'b1; d_req = 1'b1;
        tick();
        chk("lock_grant_latency", b_req, 1'b1);
        wait_done(1'b1);
        d_req = 1'b0;
        model_last = 1'b1;
        if (i_during) begin
            i_addr = ai; i_req = 1'b1;
            for (int k = 0; k < 5; k++) begin
                tick();
                chk("lock_excludes_i", b_req, 1'b0);
            end
        end
        if (do_write) begin
            push_burst(1'b1, 1'b1, a);
            if (i_during) push_burst(1'b0, 1'b0, ai);
            d_addr = a; d_we = 1'b1; d_req = 1'b1;
            tick();
            chk("lock_write_start", {b_req, b_we}, 2'b11);
            wait_done(1'b1);
            d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0;
        end else begin
            if (i_during) push_burst(1'b0, 1'b0, ai);
            d_lock = 1'b0;
            tick();
            chk("unlock_idle", b_req, 1'b0);
            if (i_during) begin
                tick();
                chk("unlock_then_i_grant", b_req, 1'b1);
            end
        end
        if (i_during) begin
            wait_done(1'b0);
            i_req = 1'b0;
            model_last = 1'b0;
        end
    endtask

    // monitor: pop and compare one expected beat per acknowledged bus beat
    always @(negedge clk) begin
        beat_t e;
        bit    exp_id;
        bit    exp_dd;
        if (mon_en) begin
            exp_id = 1'b0;
            exp_dd = 1'b0;
            chk("i_data_pass", i_data, b_rdata);
            chk("d_rdata_pass", d_rdata, b_rdata);
            chk("b_wdata_pass", b_wdata, d_wdata);
            if (prev_done) chk("bubble_after_done", b_req, 1'b0);
            if (b_req) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_req: b_req=1 addr %0h, expected no request", b_addr);
                end else begin
                    e = sb[0];
                    chk("b_addr", b_addr, e.addr);
                    chk("b_we", b_we, e.we);
                    if (b_ack) begin
                        void'(sb.pop_front());
                        beats_seen++;
                        exp_id = !e.side_d && e.last;
                        exp_dd = e.side_d && e.last;
                        chk("strobes_beat", {i_vld, d_vld, d_wrd, i_done, d_done},
                            {!e.side_d, e.side_d && !e.we, e.side_d && e.we, exp_id, exp_dd});
                    end else begin
                        chk("strobes_hold", {i_vld, d_vld, d_wrd, i_done, d_done}, 5'b0);
                    end
                end
            end else begin
                chk("idle_bus", {b_we, b_addr}, 65'b0);
                chk("strobes_idle", {i_vld, d_vld, d_wrd, i_done, d_done}, 5'b0);
            end
            chk("b_rd_i", b_rd_i, i_req && !exp_id);
            chk("b_rd_d", b_rd_d, d_req && !exp_dd);
            if (i_done) done_i_cnt++;
            if (d_done) done_d_cnt++;
            if (d_wrd) wrd_cnt++;
            prev_done = i_done || d_done;
        end
    end

    initial begin
        int start;
        int n;
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0; b_ack = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; b_rdata = '0;
        tick();
        tick();
        chk("reset_outputs", {b_req, b_we, b_addr, i_vld, i_done, d_vld, d_done, d_wrd}, 72'b0);
        rst = 1'b0;
        mon_en = 1'b1;
        model_last = 1'b0;

        // I read, ack every cycle
        ack_mode = 1;
        one_burst(1'b0, 1'b0, 64'h1000);
        tick();
        // simultaneous requests, twice (second exercises alternation if enabled)
        both_burst(64'h2000, 1'b0, 64'h1100);
        tick();
        both_burst(64'h2200, 1'b0, 64'h1200);
        tick();
        // D write with toggling ack
        ack_mode = 2;
        start = wrd_cnt;
        one_burst(1'b1, 1'b1, 64'h3000);
        chk("wrd_pulses", wrd_cnt - start, BEATS);
        tick();
        // AMO: locked read, I waits, paired write
        ack_mode = 0;
        lock_seq(64'h4000, 1'b1, 1'b1, 64'h5000);
        tick();
        // reset at beat 3 of an I burst
        ack_mode = 1;
        push_burst(1'b0, 1'b0, 64'h6000);
        i_addr = 64'h6000; i_req = 1'b1;
        start = beats_seen; n = 0;
        while (beats_seen - start < 3 && n < 50) begin tick(); n++; end
        chk("beats_before_reset", beats_seen - start, 3);
        rst = 1'b1; b_ack = 1'b0; i_req = 1'b0;
        tick();
        sb.delete();
        rst = 1'b0;
        chk("reset_midburst_idle", b_req, 1'b0);
        start = done_i_cnt;
        tick();
        chk("no_done_after_reset", done_i_cnt - start, 0);
        model_last = 1'b0;
        one_burst(1'b0, 1'b0, 64'h6000);
        tick();
        // locked read then unlock with I pending
        ack_mode = 0;
        lock_seq(64'h7000, 1'b0, 1'b1, 64'h7100);
        tick();

        // randomized mix
        for (int it = 0; it < 30; it++) begin
            ack_mode = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0: one_burst(1'b0, 1'b0, rnd_addr());
                1: one_burst(1'b1, 1'($urandom_range(0, 1)), rnd_addr());
                2: both_burst(rnd_addr(), 1'($urandom_range(0, 1)), rnd_addr());
                default: lock_seq(rnd_addr(), 1'($urandom_range(0, 1)),
                                  1'($urandom_range(0, 1)), rnd_addr());
            endcase
            repeat ($urandom_range(1, 3)) tick();
        end
        chk("queue_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
